// File: rtl/dashcam_bus_pkg.sv
// ----------------------------------------------------------------------------
// dashcam_bus_pkg
//   Shared types and constants for the dashcam memory arbiter.
//   - arb_state_e : arbiter FSM states (IDLE, BURST, DRAIN)
//   - *_DEF       : default configuration of the arbiter
//   - BEAT_BYTES  : bytes per memory beat in the default configuration
//   - ID_W        : requester index width in the default configuration
// ----------------------------------------------------------------------------
package dashcam_bus_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int LEN_W_DEF   = 3;

    localparam int BEAT_BYTES  = DATA_W_DEF / 8;
    localparam int ID_W        = $clog2(NUM_REQ_DEF);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_e;

endpackage

// File: rtl/dashcam_mem_arbiter_rr_picker.sv
// ----------------------------------------------------------------------------
// rr_picker
//   Combinational round-robin picker: selects the first set bit of 'mask'
//   at or after position 'ptr', wrapping cyclically.
//   Ports:
//     mask  in  N    candidate requesters
//     ptr   in  IDW  starting position (must be < N)
//     grant out N    one-hot grant (all zero when mask is empty)
//     idx   out IDW  index of the granted requester
//     any   out 1    at least one candidate present
// ----------------------------------------------------------------------------
module rr_picker #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   mask,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] idx,
    output logic           any
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;

    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        // Rotate the mask so that position ptr lands at bit 0; the first set
        // bit of the rotated vector is then the round-robin winner.
        dbl   = {mask, mask} >> ptr;
        rot   = dbl[N-1:0];
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any && rot[k]) begin
                any = 1'b1;
                idx = IDW'((int'(ptr) + k) % N);
            end
        end
        for (int j = 0; j < N; j++) begin
            grant[j] = any && (idx == IDW'(j));
        end
    end

endmodule

// File: rtl/dashcam_mem_arbiter.sv
// ----------------------------------------------------------------------------
// dashcam_mem_arbiter
//   Shares one memory port between NUM_REQ bus masters with per-burst
//   round-robin arbitration. The winner keeps the port for its whole burst
//   and read responses are routed back to it.
//   Optional feature macro: ARB_URGENT_PRIO_EN adds req_urgent; urgent
//   requesters win arbitration over non-urgent ones (never pre-emptive).
//   Ports:
//     clk, reset_n            clock, asynchronous active-low reset
//     req_valid/ready/we      per-requester burst request, beat accept, direction
//     req_addr/len/wdata      packed per-requester start address, beats-1, wdata
//     req_urgent              (ARB_URGENT_PRIO_EN only) urgent request flags
//     rsp_valid/rsp_rdata     one-hot read response valid, shared read data
//     mem_valid/ready/we      beat request to memory and its handshake
//     mem_addr/wdata          beat address and write data
//     mem_rvalid/rdata        in-order read data return
//     grant_id                current / last burst owner
// ----------------------------------------------------------------------------
module dashcam_mem_arbiter
    import dashcam_bus_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int LEN_W   = LEN_W_DEF
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ-1:0]          req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]    req_len,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
`ifdef ARB_URGENT_PRIO_EN
    input  logic [NUM_REQ-1:0]          req_urgent,
`endif
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        mem_valid,
    input  logic                        mem_ready,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic                        mem_rvalid,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int BPB = DATA_W / 8;

    arb_state_e        state_q,   state_d;
    logic [IDW-1:0]    owner_q,   owner_d;
    logic [ADDR_W-1:0] base_q,    base_d;
    logic [LEN_W-1:0]  len_q,     len_d;
    logic              we_q,      we_d;
    logic [LEN_W-1:0]  beat_q,    beat_d;
    logic [IDW-1:0]    rr_ptr_q,  rr_ptr_d;
    logic [LEN_W:0]    out_cnt_q, out_cnt_d;

    logic [NUM_REQ-1:0] arb_mask;
    logic [NUM_REQ-1:0] pick_grant;
    logic [IDW-1:0]     pick_idx;
    logic               pick_any;
    logic               owner_valid;
    logic [DATA_W-1:0]  owner_wdata;
    logic               rd_issue;
    logic               rsp_accept;

`ifdef ARB_URGENT_PRIO_EN
    logic [NUM_REQ-1:0] urgent_mask;
    assign urgent_mask = req_valid & req_urgent;
    // Urgent requesters form their own round-robin pool when any is present.
    assign arb_mask    = (|urgent_mask) ? urgent_mask : req_valid;
`else
    assign arb_mask    = req_valid;
`endif

    rr_picker #(
        .N   (NUM_REQ),
        .IDW (IDW)
    ) u_picker (
        .mask  (arb_mask),
        .ptr   (rr_ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Owner's live request signals; valid drives bubbles, wdata is forwarded.
    always_comb begin
        owner_valid = 1'b0;
        owner_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == IDW'(i)) begin
                owner_valid = req_valid[i];
                owner_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Responses with nothing outstanding (stray or from before a reset) are dropped.
    assign rd_issue   = (state_q == ST_BURST) && owner_valid && mem_ready && !we_q;
    assign rsp_accept = mem_rvalid && (out_cnt_q != '0);

    always_comb begin
        out_cnt_d = out_cnt_q;
        if (rd_issue && !rsp_accept) begin
            out_cnt_d = out_cnt_q + 1'b1;
        end else if (!rd_issue && rsp_accept) begin
            out_cnt_d = out_cnt_q - 1'b1;
        end
    end

    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        if (rsp_accept) begin
            rsp_rdata = mem_rdata;
            for (int i = 0; i < NUM_REQ; i++) begin
                rsp_valid[i] = (owner_q == IDW'(i));
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        base_d    = base_q;
        len_d     = len_q;
        we_d      = we_q;
        beat_d    = beat_q;
        rr_ptr_d  = rr_ptr_q;
        mem_valid = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        req_ready = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_BURST;
                    owner_d = pick_idx;
                    beat_d  = '0;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (pick_grant[i]) begin
                            base_d = req_addr[i*ADDR_W +: ADDR_W];
                            len_d  = req_len[i*LEN_W +: LEN_W];
                            we_d   = req_we[i];
                        end
                    end
                end
            end
            ST_BURST: begin
                mem_valid = owner_valid;
                mem_we    = we_q;
                // Plain modular add: bursts may wrap past the top of the address space.
                mem_addr  = base_q + ADDR_W'(beat_q) * ADDR_W'(BPB);
                mem_wdata = owner_wdata;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (owner_q == IDW'(i)) begin
                        req_ready[i] = mem_ready;
                    end
                end
                if (owner_valid && mem_ready) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == len_q) begin
                        rr_ptr_d = (owner_q == IDW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                        if (we_q || (out_cnt_d == '0)) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_DRAIN;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (out_cnt_d == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign grant_id = owner_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            owner_q   <= '0;
            base_q    <= '0;
            len_q     <= '0;
            we_q      <= 1'b0;
            beat_q    <= '0;
            rr_ptr_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            base_q    <= base_d;
            len_q     <= len_d;
            we_q      <= we_d;
            beat_q    <= beat_d;
            rr_ptr_q  <= rr_ptr_d;
            out_cnt_q <= out_cnt_d;
        end
    end

endmodule

// File: tb/tb_dashcam_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dashcam_mem_arbiter
//   Directed bench for dashcam_mem_arbiter with a small in-order memory
//   responder (fixed read latency) and hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_dashcam_mem_arbiter;
    import dashcam_bus_pkg::*;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 3;

    logic             clk;
    logic             reset_n;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [NR-1:0]    req_we;
    logic [NR*AW-1:0] req_addr;
    logic [NR*LW-1:0] req_len;
    logic [NR*DW-1:0] req_wdata;
`ifdef ARB_URGENT_PRIO_EN
    logic [NR-1:0]    req_urgent;
`endif
    logic [NR-1:0]    rsp_valid;
    logic [DW-1:0]    rsp_rdata;
    logic             mem_valid;
    logic             mem_ready;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_wdata;
    logic             mem_rvalid;
    logic [DW-1:0]    mem_rdata;
    logic [1:0]       grant_id;

    dashcam_mem_arbiter #(
        .NUM_REQ (NR),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .LEN_W   (LW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .req_wdata  (req_wdata),
`ifdef ARB_URGENT_PRIO_EN
        .req_urgent (req_urgent),
`endif
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .grant_id   (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bench bookkeeping
    int          cyc;
    int          rlat;
    bit          toggle_ready;
    bit          rst_now;
    bit          chk_mirror;
    bit          chk_drain;
    bit          pre_rst_mv;
    logic [AW-1:0] pre_rst_addr;
    int          due_q[$];
    logic [AW-1:0] addr_log[$];
    int          gnt_log[$];
    int          lens[NR];
    int          bursts_left[NR];
    int          beats_in_burst[NR];
    int          rsp_cnt[NR];
    logic [NR-1:0] drop_mask;
    int          total_beats;
    int          drain_cycles;
    int          last_drain_cyc;
    int          last_rsp_cyc;

    task automatic clear_bench();
        due_q.delete();
        addr_log.delete();
        gnt_log.delete();
        for (int i = 0; i < NR; i++) begin
            lens[i] = 0; bursts_left[i] = 0; beats_in_burst[i] = 0; rsp_cnt[i] = 0;
        end
        drop_mask = '0; total_beats = 0; drain_cycles = 0;
        last_drain_cyc = -1; last_rsp_cyc = -2;
        toggle_ready = 0; rst_now = 0; chk_mirror = 0; chk_drain = 0; rlat = 2;
    endtask

    task automatic reset_dut();
        reset_n = 1'b0;
        req_valid = '0; req_we = '0; req_addr = '0; req_len = '0; req_wdata = '0;
`ifdef ARB_URGENT_PRIO_EN
        req_urgent = '0;
`endif
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        clear_bench();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic set_req(input int i, input bit we, input logic [AW-1:0] addr,
                           input int len, input logic [DW-1:0] wd, input int nb);
        req_we[i]                = we;
        req_addr[i*AW +: AW]     = addr;
        req_len[i*LW +: LW]      = LW'(len);
        req_wdata[i*DW +: DW]    = wd;
        lens[i]                  = len;
        bursts_left[i]           = nb;
        req_valid[i]             = 1'b1;
    endtask

    // One clock: drive inputs at the falling edge, observe 1 time unit later.
    task automatic cycle();
        logic [NR-1:0] exp_rdy;
        int g;
        @(negedge clk);
        cyc++;
        req_valid = req_valid & ~drop_mask;
        drop_mask = '0;
        mem_ready = toggle_ready ? (cyc % 2 == 0) : 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        if (due_q.size() > 0 && due_q[0] <= cyc) begin
            void'(due_q.pop_front());
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hD000_0000 | DW'(cyc);
        end
        if (rst_now) begin
            #1;
            pre_rst_mv   = mem_valid;
            pre_rst_addr = mem_addr;
            reset_n      = 1'b0;
        end
        #1;
        for (int i = 0; i < NR; i++) begin
            if (rsp_valid[i]) begin
                rsp_cnt[i]++;
                last_rsp_cyc = cyc;
                check("rsp_rdata", rsp_rdata, mem_rdata);
            end
        end
        if (chk_mirror && dut.state_q == ST_BURST) begin
            exp_rdy = '0;
            exp_rdy[1] = mem_ready;
            check("req_ready_mirror", req_ready, exp_rdy);
            check("mem_wdata_fwd", mem_wdata, req_wdata[1*DW +: DW]);
            check("mem_we_write", mem_we, 1'b1);
        end
        if (chk_drain && dut.state_q == ST_DRAIN) begin
            drain_cycles++;
            last_drain_cyc = cyc;
            check("drain_no_mem_valid", mem_valid, 1'b0);
            check("drain_owner_kept", grant_id, 2'd0);
        end
        if (mem_valid && mem_ready && reset_n) begin
            g = int'(grant_id);
            if (beats_in_burst[g] == 0) gnt_log.push_back(g);
            addr_log.push_back(mem_addr);
            total_beats++;
            if (!mem_we) due_q.push_back(cyc + rlat);
            beats_in_burst[g]++;
            if (beats_in_burst[g] == lens[g] + 1) begin
                beats_in_burst[g] = 0;
                bursts_left[g]--;
                if (bursts_left[g] <= 0) drop_mask[g] = 1'b1;
            end
        end
    endtask

    task automatic run_done(input string tag, input int max);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!(req_valid == '0 && dut.state_q == ST_IDLE && due_q.size() == 0) && n < max);
        check({tag, "_completes"}, (n < max), 1'b1);
    endtask

    initial begin
        cyc = 0;
        reset_n = 1'b0;
        req_valid = '0; req_we = '0; req_addr = '0; req_len = '0; req_wdata = '0;
`ifdef ARB_URGENT_PRIO_EN
        req_urgent = '0;
`endif
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        clear_bench();

        // Reset state
        #12;
        check("rst_mem_valid", mem_valid, 1'b0);
        check("rst_req_ready", req_ready, 4'h0);
        check("rst_rsp_valid", rsp_valid, 4'h0);
        check("rst_grant_id",  grant_id, 2'd0);
        check("rst_mem_addr",  mem_addr, 32'h0);
        check("rst_state",     dut.state_q, ST_IDLE);
        check("rst_rr_ptr",    dut.rr_ptr_q, 2'd0);

        // 1: single read burst len=3 from req0
        reset_dut();
        rlat = 2;
        set_req(0, 1'b0, 32'h0000_1000, 3, '0, 1);
        run_done("t1", 100);
        check("t1_beats", addr_log.size(), 4);
        if (addr_log.size() == 4) begin
            check("t1_addr0", addr_log[0], 32'h1000);
            check("t1_addr1", addr_log[1], 32'h1004);
            check("t1_addr2", addr_log[2], 32'h1008);
            check("t1_addr3", addr_log[3], 32'h100C);
        end
        check("t1_rsp0", rsp_cnt[0], 4);
        check("t1_state", dut.state_q, ST_IDLE);
        check("t1_rr_ptr", dut.rr_ptr_q, 2'd1);

        // 2: all four valid, len=0 writes -> grants 0,1,2,3,0
        reset_dut();
        set_req(0, 1'b1, 32'h0000_A000, 0, 32'h0A0A_0A0A, 2);
        set_req(1, 1'b1, 32'h0000_B000, 0, 32'h0B0B_0B0B, 1);
        set_req(2, 1'b1, 32'h0000_C000, 0, 32'h0C0C_0C0C, 1);
        set_req(3, 1'b1, 32'h0000_D000, 0, 32'h0D0D_0D0D, 1);
        run_done("t2", 100);
        check("t2_grants", gnt_log.size(), 5);
        if (gnt_log.size() == 5) begin
            check("t2_g0", gnt_log[0], 0);
            check("t2_g1", gnt_log[1], 1);
            check("t2_g2", gnt_log[2], 2);
            check("t2_g3", gnt_log[3], 3);
            check("t2_g4", gnt_log[4], 0);
        end

        // 3: req1 write len=7, mem_ready toggling, address wrap at top of space
        reset_dut();
        toggle_ready = 1;
        chk_mirror   = 1;
        set_req(1, 1'b1, 32'hFFFF_FFF0, 7, 32'h1234_5678, 1);
        run_done("t3", 100);
        chk_mirror = 0;
        check("t3_beats", addr_log.size(), 8);
        if (addr_log.size() == 8) begin
            check("t3_addr0", addr_log[0], 32'hFFFF_FFF0);
            check("t3_addr4_wrap", addr_log[4], 32'h0000_0000);
            check("t3_addr7", addr_log[7], 32'h0000_000C);
        end
        check("t3_rr_ptr", dut.rr_ptr_q, 2'd2);

        // 4: read len=1 with slow responses; req2 waits until drain finishes
        reset_dut();
        rlat = 6;
        chk_drain = 1;
        set_req(0, 1'b0, 32'h0000_4000, 1, '0, 1);
        set_req(2, 1'b1, 32'h0000_5000, 0, 32'h5555_AAAA, 1);
        run_done("t4", 100);
        chk_drain = 0;
        check("t4_drain_cycles", drain_cycles, 6);
        check("t4_drain_ends_on_last_rsp", last_drain_cyc, last_rsp_cyc);
        check("t4_rsp0", rsp_cnt[0], 2);
        check("t4_grants", gnt_log.size(), 2);
        if (gnt_log.size() == 2) begin
            check("t4_g0", gnt_log[0], 0);
            check("t4_g1", gnt_log[1], 2);
        end

        // 5: reset during beat 2 of a len=7 read; late and stray rvalids ignored
        reset_dut();
        rlat = 3;
        set_req(3, 1'b0, 32'h0000_3000, 7, '0, 1);
        begin
            int n;
            n = 0;
            while (total_beats < 2 && n < 50) begin
                cycle();
                n++;
            end
        end
        check("t5_two_beats", total_beats, 2);
        rst_now = 1;
        cycle();
        rst_now = 0;
        check("t5_mv_before_rst", pre_rst_mv, 1'b1);
        check("t5_addr_beat2", pre_rst_addr, 32'h0000_3008);
        check("t5_mv_in_rst", mem_valid, 1'b0);
        req_valid = '0;
        repeat (4) cycle();
        reset_n = 1'b1;
        due_q.push_back(cyc + 2);
        repeat (4) cycle();
        check("t5_rsp_ignored", rsp_cnt[3], 0);
        check("t5_out_cnt", dut.out_cnt_q, 4'd0);
        check("t5_state", dut.state_q, ST_IDLE);
        check("t5_rr_ptr", dut.rr_ptr_q, 2'd0);
        check("t5_mem_valid", mem_valid, 1'b0);

`ifdef ARB_URGENT_PRIO_EN
        // 6: urgent req3 overtakes pending non-urgent req1 after req0's burst
        reset_dut();
        set_req(0, 1'b1, 32'h0000_6000, 3, 32'h6666_6666, 1);
        begin
            int n;
            n = 0;
            while (gnt_log.size() < 1 && n < 20) begin
                cycle();
                n++;
            end
        end
        set_req(1, 1'b1, 32'h0000_7000, 0, 32'h7777_7777, 1);
        set_req(3, 1'b1, 32'h0000_8000, 0, 32'h8888_8888, 1);
        req_urgent[3] = 1'b1;
        run_done("t6", 100);
        check("t6_grants", gnt_log.size(), 3);
        if (gnt_log.size() == 3) begin
            check("t6_g0", gnt_log[0], 0);
            check("t6_g1_urgent", gnt_log[1], 3);
            check("t6_g2", gnt_log[2], 1);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
